kl8_serial_rx: RTL and testbench

Asynchronous serial receiver for the console path. It is the receiving end of the PDP-8/e teleprinter transmitter: it decodes the 8N1 stream on `rx` into bytes and holds each one behind a keyboard-style flag. The CPU's keyboard IOTs sample that flag and clear it. The block sits between the `rx` pin and the KL8 keyboard register logic, in the `clk` domain.

---
 rtl/kl8_serial_rx.sv | 154 +++++++++++++++
 tb/tb_kl8_serial_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/kl8_serial_rx.sv
// 8N1 asynchronous receiver feeding the KL8 keyboard register: decodes rx into
// bytes and holds each one behind a sticky keyboard flag until KCC/KRB clears it.
module kl8_serial_rx #(
  parameter int clock_frequency = 100000000,
  parameter int baud_rate       = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  input  logic       flag_clr,
  output logic [0:7] kbd_data,
  output logic       kbd_flag,
  output logic       overrun,
  output logic       framing_err,
  output logic       busy
);

  // Clocks per bit, rounded to nearest; must be at least 8.
  localparam int DIV = (clock_frequency + baud_rate / 2) / baud_rate;
  localparam logic [15:0] HALF_LOAD = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE,
    BRK
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sync_1;
  logic        rxs;
  logic [15:0] tmr;
  logic [15:0] tmr_next;
  logic [2:0]  bitn;
  logic [2:0]  bitn_next;
  logic [7:0]  shreg;
  logic [7:0]  shreg_next;
  logic        stop_bit;
  logic        stop_bit_next;
  logic        tmr_zero;

  assign tmr_zero = (tmr == 16'd0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_1 <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_1 <= rx;
      rxs    <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tmr      <= 16'd0;
      bitn     <= 3'd0;
      shreg    <= 8'd0;
      stop_bit <= 1'b1;
    end else begin
      state    <= state_next;
      tmr      <= tmr_next;
      bitn     <= bitn_next;
      shreg    <= shreg_next;
      stop_bit <= stop_bit_next;
    end
  end

  // DONE is the one-cycle slot after the stop sample in which the byte is
  // published; it keeps busy high until the same edge that raises kbd_flag.
  always_comb begin
    state_next    = state;
    tmr_next      = tmr;
    bitn_next     = bitn;
    shreg_next    = shreg;
    stop_bit_next = stop_bit;
    case (state)
      IDLE: begin
        if (!rxs) begin
          tmr_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (!tmr_zero) begin
          tmr_next = tmr - 16'd1;
        end else if (rxs) begin
          state_next = IDLE;
        end else begin
          tmr_next   = FULL_LOAD;
          bitn_next  = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (!tmr_zero) begin
          tmr_next = tmr - 16'd1;
        end else begin
          shreg_next = {rxs, shreg[7:1]};
          tmr_next   = FULL_LOAD;
          bitn_next  = bitn + 3'd1;
          if (bitn == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (!tmr_zero) begin
          tmr_next = tmr - 16'd1;
        end else begin
          stop_bit_next = rxs;
          state_next    = DONE;
        end
      end
      DONE: begin
        state_next = stop_bit ? IDLE : BRK;
      end
      BRK: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A completion always wins over flag_clr; a coincident clear still drops any
  // pending overrun so KCC leaves the register holding exactly one fresh byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      kbd_data    <= 8'd0;
      kbd_flag    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else if (state == DONE) begin
      kbd_data    <= shreg;
      kbd_flag    <= 1'b1;
      framing_err <= ~stop_bit;
      overrun     <= ~flag_clr & (overrun | kbd_flag);
    end else if (flag_clr) begin
      kbd_flag <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kl8_serial_rx.sv
// Scoreboard bench for kl8_serial_rx at DIV=16: the stimulus pushes expected
// bytes, and a monitor pops and compares on every byte completion.
module tb_kl8_serial_rx;

  localparam int DIV = 16;
  // Flag edge = first edge sampling the low start bit + 2 + DIV/2 + 9*DIV + 1.
  localparam int LATENCY = 1 + 2 + DIV / 2 + 9 * DIV + 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       flag_clr = 1'b0;
  logic [0:7] kbd_data;
  logic       kbd_flag;
  logic       overrun;
  logic       framing_err;
  logic       busy;

  kl8_serial_rx #(
    .clock_frequency(1600000),
    .baud_rate      (100000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .flag_clr   (flag_clr),
    .kbd_data   (kbd_data),
    .kbd_flag   (kbd_flag),
    .overrun    (overrun),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       ovr;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  logic prev_flag = 1'b0;
  logic prev_busy = 1'b0;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic bitTime(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(logic [7:0] data, logic stop, int hold_low);
    rx = 1'b0;
    bitTime(DIV);
    for (int k = 0; k < 8; k++) begin
      rx = data[k];
      bitTime(DIV);
    end
    rx = stop;
    bitTime(DIV);
    if (hold_low > 0) begin
      bitTime(hold_low);
      rx = 1'b1;
    end
  endtask

  task automatic applyStimulus(logic [7:0] data, logic stop, int hold_low, logic exp_ovr);
    sb.push_back('{data, ~stop, exp_ovr, cyc + LATENCY});
    sendFrame(data, stop, hold_low);
  endtask

  task automatic clearFlag();
    flag_clr = 1'b1;
    bitTime(1);
    flag_clr = 1'b0;
  endtask

  // A completion shows as kbd_flag rising, or, when the flag was already up,
  // busy dropping out of a good stop bit (BRK exits carry framing_err=1).
  always @(negedge clk) begin
    if (resetn && ((kbd_flag && !prev_flag) ||
                   (prev_busy && !busy && kbd_flag && !framing_err))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte: got %0h at cycle %0d, expected no byte",
                 kbd_data, cyc);
      end else begin
        mon_item = sb.pop_front();
        checkOutput("flag_cycle", 32'(cyc), 32'(mon_item.at));
        checkOutput("kbd_data", 32'(kbd_data), 32'(mon_item.data));
        checkOutput("framing_err", 32'(framing_err), 32'(mon_item.fe));
        checkOutput("overrun", 32'(overrun), 32'(mon_item.ovr));
      end
    end
    prev_flag = kbd_flag;
    prev_busy = busy;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bitTime(3);
    checkOutput("rst_data", 32'(kbd_data), 32'(0));
    checkOutput("rst_flag", 32'(kbd_flag), 32'(0));
    checkOutput("rst_overrun", 32'(overrun), 32'(0));
    checkOutput("rst_framing", 32'(framing_err), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    resetn = 1'b1;
    bitTime(5);

    $display("[TB] single byte 0x8D");
    applyStimulus(8'h8D, 1'b1, 0, 1'b0);
    bitTime(2);
    checkOutput("single_busy", 32'(busy), 32'(0));
    checkOutput("single_flag", 32'(kbd_flag), 32'(1));

    $display("[TB] back-to-back 0xC1 0xC2");
    clearFlag();
    t0 = cyc;
    fork
      begin
        applyStimulus(8'hC1, 1'b1, 0, 1'b0);
        applyStimulus(8'hC2, 1'b1, 0, 1'b0);
      end
      begin
        bitTime(180);
        flag_clr = 1'b1;
        bitTime(1);
        flag_clr = 1'b0;
        checkOutput("b2b_clear_flag", 32'(kbd_flag), 32'(0));
      end
    join
    bitTime(2);

    $display("[TB] overrun 0x3C 0xA5");
    clearFlag();
    applyStimulus(8'h3C, 1'b1, 0, 1'b0);
    applyStimulus(8'hA5, 1'b1, 0, 1'b1);
    bitTime(2);
    checkOutput("ovr_overrun", 32'(overrun), 32'(1));
    checkOutput("ovr_flag", 32'(kbd_flag), 32'(1));
    clearFlag();
    checkOutput("clr_flag", 32'(kbd_flag), 32'(0));
    checkOutput("clr_overrun", 32'(overrun), 32'(0));
    checkOutput("clr_data_held", 32'(kbd_data), 32'(8'hA5));
    checkOutput("clr_framing_held", 32'(framing_err), 32'(0));

    $display("[TB] flag_clr on completion 0x12 0x34");
    t0 = cyc;
    fork
      begin
        applyStimulus(8'h12, 1'b1, 0, 1'b0);
        applyStimulus(8'h34, 1'b1, 0, 1'b0);
      end
      begin
        bitTime(DIV * 10 + LATENCY - 1);
        flag_clr = 1'b1;
        bitTime(1);
        flag_clr = 1'b0;
      end
    join
    bitTime(2);
    checkOutput("simul_flag", 32'(kbd_flag), 32'(1));
    checkOutput("simul_overrun", 32'(overrun), 32'(0));

    $display("[TB] false start");
    clearFlag();
    rx = 1'b0;
    bitTime(6);
    rx = 1'b1;
    bitTime(4);
    checkOutput("fs_busy_pulse", 32'(busy), 32'(1));
    bitTime(1);
    checkOutput("fs_busy_idle", 32'(busy), 32'(0));
    bitTime(20);
    checkOutput("fs_flag", 32'(kbd_flag), 32'(0));

    $display("[TB] framing error 0x55");
    applyStimulus(8'h55, 1'b0, 100, 1'b0);
    bitTime(2);
    checkOutput("brk_busy_held", 32'(busy), 32'(1));
    bitTime(1);
    checkOutput("brk_busy_drop", 32'(busy), 32'(0));
    checkOutput("brk_framing", 32'(framing_err), 32'(1));
    checkOutput("brk_flag", 32'(kbd_flag), 32'(1));
    bitTime(40);

    $display("[TB] reset mid-frame");
    fork
      sendFrame(8'hFF, 1'b1, 0);
      begin
        bitTime(5 * DIV + 8);
        checkOutput("midrst_busy_before", 32'(busy), 32'(1));
        resetn = 1'b0;
        bitTime(1);
        checkOutput("midrst_data", 32'(kbd_data), 32'(0));
        checkOutput("midrst_flag", 32'(kbd_flag), 32'(0));
        checkOutput("midrst_overrun", 32'(overrun), 32'(0));
        checkOutput("midrst_framing", 32'(framing_err), 32'(0));
        checkOutput("midrst_busy", 32'(busy), 32'(0));
        resetn = 1'b1;
      end
    join
    bitTime(20 * DIV);
    applyStimulus(8'h41, 1'b1, 0, 1'b0);
    bitTime(10);

    checkOutput("pending_bytes", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
